ram_wbuffer_pack: RTL and testbench

//   Write-side counterpart of the RAM read-buffer entries. Collects the MXU result

---
 rtl/ram_wbuffer_pack.sv | 157 +++++++++++++++
 tb/tb_ram_wbuffer_pack.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_wbuffer_pack.sv
// ram_wbuffer_pack
// Packs a byte stream into RAM lines through two ping-pong entries. One entry
// fills from the byte stream while the other holds its strobed write request
// until the RAM arbiter grants it. Lines leave in the order their descriptors
// were accepted.
//
// entry state | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | free; may accept a line descriptor when it is the fill entry
// ST_FILL     | collecting bytes, one lane per handshake, start -> end
// ST_WAIT_WR  | line complete; drives ram_wr_* when it is the write entry
module ram_wbuffer_pack #(
  parameter int RAM_WIDTH = 128,
  parameter int RAM_DEPTH = 256,
  parameter int ENT_NUM   = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_vld,
  output logic                             cfg_rdy,
  input  logic [$clog2(RAM_DEPTH)-1:0]     cfg_addr,
  input  logic [$clog2(RAM_WIDTH/8)-1:0]   cfg_start_byte,
  input  logic [$clog2(RAM_WIDTH/8)-1:0]   cfg_end_byte,
  input  logic                             in_vld,
  input  logic [7:0]                       in_data,
  output logic                             in_rdy,
  output logic                             ram_wr_req,
  output logic [$clog2(RAM_DEPTH)-1:0]     ram_wr_addr,
  output logic [RAM_WIDTH-1:0]             ram_wr_data,
  output logic [RAM_WIDTH/8-1:0]           ram_wr_strb,
  input  logic                             ram_wr_gnt,
  output logic                             line_done,
  output logic                             busy
);

  localparam int LANES = RAM_WIDTH / 8;
  localparam int LW    = $clog2(LANES);
  localparam int AW    = $clog2(RAM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_WAIT_WR = 2'd2
  } ent_state_t;

  // Per-entry registers; the pointers are one bit because there are exactly two entries.
  ent_state_t           r_state [ENT_NUM];
  logic [AW-1:0]        r_addr  [ENT_NUM];
  logic [LW-1:0]        r_start [ENT_NUM];
  logic [LW-1:0]        r_end   [ENT_NUM];
  logic [LW-1:0]        r_cur   [ENT_NUM];
  logic [RAM_WIDTH-1:0] r_data  [ENT_NUM];
  logic [LANES-1:0]     r_strb  [ENT_NUM];
  logic                 r_fill_ptr;
  logic                 r_wr_ptr;

  logic                 w_cfg_acc;
  logic                 w_in_acc;
  logic                 w_wr_acc;
  logic                 w_last_byte;
  logic                 w_descend;
  logic [LW-1:0]        w_next_cur;
  logic                 w_busy;

  // Handshakes are qualified only by the state of the entry each pointer selects.
  assign cfg_rdy     = (r_state[r_fill_ptr] == ST_IDLE);
  assign in_rdy      = (r_state[r_fill_ptr] == ST_FILL);
  assign ram_wr_req  = (r_state[r_wr_ptr] == ST_WAIT_WR);

  assign w_cfg_acc   = cfg_vld & cfg_rdy;
  assign w_in_acc    = in_vld & in_rdy;
  assign w_wr_acc    = ram_wr_req & ram_wr_gnt;

  // Direction is fixed per line by the descriptor; cur never steps past end,
  // so the 4-bit lane counter cannot wrap.
  assign w_last_byte = (r_cur[r_fill_ptr] == r_end[r_fill_ptr]);
  assign w_descend   = (r_start[r_fill_ptr] > r_end[r_fill_ptr]);
  assign w_next_cur  = w_descend ? (r_cur[r_fill_ptr] - LW'(1))
                                 : (r_cur[r_fill_ptr] + LW'(1));

  // Write port is driven straight from the selected entry so it stays stable while stalled.
  assign ram_wr_addr = r_addr[r_wr_ptr];
  assign ram_wr_data = r_data[r_wr_ptr];
  assign ram_wr_strb = r_strb[r_wr_ptr];
  assign line_done   = w_wr_acc;
  assign busy        = w_busy;

  // Busy whenever any entry holds a descriptor.
  always_comb begin
    w_busy = 1'b0;
    for (int e = 0; e < ENT_NUM; e++) begin
      if (r_state[e] != ST_IDLE) w_busy = 1'b1;
    end
  end

  // Entry state machines, descriptors, lane counters and the two ping-pong pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < ENT_NUM; e++) begin
        r_state[e] <= ST_IDLE;
        r_addr[e]  <= '0;
        r_start[e] <= '0;
        r_end[e]   <= '0;
        r_cur[e]   <= '0;
      end
      r_fill_ptr <= 1'b0;
      r_wr_ptr   <= 1'b0;
    end else begin
      // cfg and byte acceptance need different states of the same entry, so at
      // most one of them fires; a grant always targets a WAIT_WR entry, which
      // can never be the one being configured or filled.
      if (w_cfg_acc) begin
        r_state[r_fill_ptr] <= ST_FILL;
        r_addr[r_fill_ptr]  <= cfg_addr;
        r_start[r_fill_ptr] <= cfg_start_byte;
        r_end[r_fill_ptr]   <= cfg_end_byte;
        r_cur[r_fill_ptr]   <= cfg_start_byte;
      end
      if (w_in_acc) begin
        if (w_last_byte) begin
          r_state[r_fill_ptr] <= ST_WAIT_WR;
          r_fill_ptr          <= ~r_fill_ptr;
        end else begin
          r_cur[r_fill_ptr]   <= w_next_cur;
        end
      end
      if (w_wr_acc) begin
        r_state[r_wr_ptr] <= ST_IDLE;
        r_wr_ptr          <= ~r_wr_ptr;
      end
    end
  end

  // Line data and strobes: cleared on descriptor accept, one lane set per accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < ENT_NUM; e++) begin
        r_data[e] <= '0;
        r_strb[e] <= '0;
      end
    end else begin
      if (w_cfg_acc) begin
        r_data[r_fill_ptr] <= '0;
        r_strb[r_fill_ptr] <= '0;
      end
      if (w_in_acc) begin
        for (int l = 0; l < LANES; l++) begin
          if (r_cur[r_fill_ptr] == LW'(l)) begin
            r_data[r_fill_ptr][8*l +: 8] <= in_data;
            r_strb[r_fill_ptr][l]        <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_wbuffer_pack.sv
// Directed bench for ram_wbuffer_pack: each task drives one scenario and checks
// the write port, handshakes and the captured RAM writes against constants.
module tb_ram_wbuffer_pack;

  logic         clk;
  logic         rst_n;
  logic         cfg_vld;
  logic         cfg_rdy;
  logic [7:0]   cfg_addr;
  logic [3:0]   cfg_start_byte;
  logic [3:0]   cfg_end_byte;
  logic         in_vld;
  logic [7:0]   in_data;
  logic         in_rdy;
  logic         ram_wr_req;
  logic [7:0]   ram_wr_addr;
  logic [127:0] ram_wr_data;
  logic [15:0]  ram_wr_strb;
  logic         ram_wr_gnt;
  logic         line_done;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int done_cnt = 0;

  logic [7:0]   q_addr[$];
  logic [127:0] q_data[$];
  logic [15:0]  q_strb[$];

  ram_wbuffer_pack dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy), .cfg_addr(cfg_addr),
    .cfg_start_byte(cfg_start_byte), .cfg_end_byte(cfg_end_byte),
    .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
    .ram_wr_req(ram_wr_req), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_wr_strb(ram_wr_strb), .ram_wr_gnt(ram_wr_gnt),
    .line_done(line_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Inputs only change 1 time unit after a rising edge, so the falling edge
  // sees exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (ram_wr_req && ram_wr_gnt) begin
      q_addr.push_back(ram_wr_addr);
      q_data.push_back(ram_wr_data);
      q_strb.push_back(ram_wr_strb);
    end
    if (line_done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
    q_strb.delete();
    done_cnt = 0;
  endtask

  task automatic send_cfg(input logic [7:0] a, input logic [3:0] s, input logic [3:0] e);
    bit ok = 0;
    cfg_vld = 1'b1; cfg_addr = a; cfg_start_byte = s; cfg_end_byte = e;
    for (int n = 0; n < 200; n++) begin
      if (cfg_rdy) begin
        tick();
        ok = 1;
        break;
      end
      tick();
    end
    cfg_vld = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL cfg_timeout addr=%h got cfg_rdy=0 need cfg_rdy=1", a);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit ok = 0;
    in_vld = 1'b1; in_data = d;
    for (int n = 0; n < 200; n++) begin
      if (in_rdy) begin
        tick();
        ok = 1;
        break;
      end
      tick();
    end
    in_vld = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL byte_timeout data=%h got in_rdy=0 need in_rdy=1", d);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_vld = 0; cfg_addr = 0; cfg_start_byte = 0; cfg_end_byte = 0;
    in_vld = 0; in_data = 0; ram_wr_gnt = 0;
    repeat (2) tick();
    checks++; if (cfg_rdy !== 1'b1) begin errors++; $display("FAIL rst_cfg_rdy got %b need 1", cfg_rdy); end
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL rst_in_rdy got %b need 0", in_rdy); end
    checks++; if (ram_wr_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b need 0", ram_wr_req); end
    checks++; if (ram_wr_addr !== 8'h00) begin errors++; $display("FAIL rst_addr got %h need 00", ram_wr_addr); end
    checks++; if (ram_wr_data !== 128'h0) begin errors++; $display("FAIL rst_data got %h need 0", ram_wr_data); end
    checks++; if (ram_wr_strb !== 16'h0) begin errors++; $display("FAIL rst_strb got %h need 0", ram_wr_strb); end
    checks++; if (busy !== 1'b0 || line_done !== 1'b0) begin errors++; $display("FAIL rst_busy_done got %b%b need 00", busy, line_done); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ascending_full();
    clear_q();
    ram_wr_gnt = 1'b1;
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL t1_in_rdy_idle got %b need 0", in_rdy); end
    send_cfg(8'h10, 4'd0, 4'd15);
    checks++; if (in_rdy !== 1'b1 || cfg_rdy !== 1'b0) begin errors++; $display("FAIL t1_rdy_after_cfg got in=%b cfg=%b need in=1 cfg=0", in_rdy, cfg_rdy); end
    for (int i = 0; i < 15; i++) send_byte(8'(i));
    checks++; if (ram_wr_req !== 1'b0) begin errors++; $display("FAIL t1_req_early got %b need 0", ram_wr_req); end
    send_byte(8'h0F);
    checks++; if (ram_wr_req !== 1'b1 || line_done !== 1'b1) begin errors++; $display("FAIL t1_req_latency got req=%b done=%b need 1 1", ram_wr_req, line_done); end
    checks++; if (ram_wr_addr !== 8'h10) begin errors++; $display("FAIL t1_addr got %h need 10", ram_wr_addr); end
    checks++; if (ram_wr_data !== 128'h0F0E0D0C0B0A09080706050403020100) begin errors++; $display("FAIL t1_data got %h need 0F0E..0100", ram_wr_data); end
    checks++; if (ram_wr_strb !== 16'hFFFF) begin errors++; $display("FAIL t1_strb got %h need FFFF", ram_wr_strb); end
    checks++; if (in_rdy !== 1'b0 || cfg_rdy !== 1'b1) begin errors++; $display("FAIL t1_rdy_after_last got in=%b cfg=%b need in=0 cfg=1", in_rdy, cfg_rdy); end
    tick();
    checks++; if (line_done !== 1'b0 || ram_wr_req !== 1'b0) begin errors++; $display("FAIL t1_done_pulse got done=%b req=%b need 0 0", line_done, ram_wr_req); end
    checks++; if (done_cnt !== 1 || q_addr.size() !== 1) begin errors++; $display("FAIL t1_write_count got done=%0d writes=%0d need 1 1", done_cnt, q_addr.size()); end
  endtask

  task automatic test_descending();
    clear_q();
    ram_wr_gnt = 1'b1;
    send_cfg(8'h11, 4'd12, 4'd3);
    for (int i = 0; i < 10; i++) send_byte(8'hA0 + 8'(i));
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL t2_in_rdy_end got %b need 0", in_rdy); end
    tick();
    checks++;
    if (q_addr.size() !== 1) begin
      errors++; $display("FAIL t2_write_count got %0d need 1", q_addr.size());
    end else begin
      if (q_addr[0] !== 8'h11 || q_strb[0] !== 16'h1FF8 || q_data[0] !== 128'h000000A0A1A2A3A4A5A6A7A8A9000000) begin
        errors++; $display("FAIL t2_line got addr=%h strb=%h data=%h need 11 1FF8 000000A0A1..A9000000", q_addr[0], q_strb[0], q_data[0]);
      end
    end
  endtask

  task automatic test_single_byte();
    clear_q();
    ram_wr_gnt = 1'b1;
    send_cfg(8'h12, 4'd7, 4'd7);
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL t3_in_rdy_open got %b need 1", in_rdy); end
    send_byte(8'h5A);
    checks++; if (in_rdy !== 1'b0 || ram_wr_req !== 1'b1) begin errors++; $display("FAIL t3_after_byte got in_rdy=%b req=%b need 0 1", in_rdy, ram_wr_req); end
    checks++; if (ram_wr_strb !== 16'h0080 || ram_wr_data !== 128'h00000000000000005A00000000000000) begin
      errors++; $display("FAIL t3_line got strb=%h data=%h need 0080 lane7=5A", ram_wr_strb, ram_wr_data); end
    tick();
    checks++; if (q_addr.size() !== 1 || busy !== 1'b0) begin errors++; $display("FAIL t3_written got writes=%0d busy=%b need 1 0", q_addr.size(), busy); end
  endtask

  task automatic test_backpressure();
    clear_q();
    ram_wr_gnt = 1'b0;
    send_cfg(8'h20, 4'd0, 4'd15);
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
    send_cfg(8'h21, 4'd0, 4'd15);
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i));
    cfg_vld = 1'b1; cfg_addr = 8'h22; cfg_start_byte = 4'd0; cfg_end_byte = 4'd15;
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (cfg_rdy !== 1'b0 || in_rdy !== 1'b0 || ram_wr_req !== 1'b1 || ram_wr_addr !== 8'h20 ||
          ram_wr_strb !== 16'hFFFF || ram_wr_data !== 128'h1F1E1D1C1B1A19181716151413121110) begin
        errors++;
        $display("FAIL t4_stall got cfg_rdy=%b in_rdy=%b req=%b addr=%h strb=%h data=%h need 0 0 1 20 FFFF line1",
                 cfg_rdy, in_rdy, ram_wr_req, ram_wr_addr, ram_wr_strb, ram_wr_data);
      end
      tick();
    end
    ram_wr_gnt = 1'b1;
    checks++; if (cfg_rdy !== 1'b0) begin errors++; $display("FAIL t4_no_bypass got %b need 0", cfg_rdy); end
    tick();
    checks++; if (cfg_rdy !== 1'b1 || q_addr.size() !== 1) begin errors++; $display("FAIL t4_freed got cfg_rdy=%b writes=%0d need 1 1", cfg_rdy, q_addr.size()); end
    send_cfg(8'h22, 4'd0, 4'd15);
    for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i));
    tick();
    checks++;
    if (q_addr.size() !== 3) begin
      errors++; $display("FAIL t4_write_count got %0d need 3", q_addr.size());
    end else begin
      if (q_addr[0] !== 8'h20 || q_addr[1] !== 8'h21 || q_addr[2] !== 8'h22) begin
        errors++; $display("FAIL t4_order got %h %h %h need 20 21 22", q_addr[0], q_addr[1], q_addr[2]);
      end
      checks++;
      if (q_data[1] !== 128'h2F2E2D2C2B2A29282726252423222120 || q_data[2] !== 128'h3F3E3D3C3B3A39383736353433323130) begin
        errors++; $display("FAIL t4_data got %h %h need line2 line3", q_data[1], q_data[2]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    clear_q();
    ram_wr_gnt = 1'b1;
    t0 = cyc;
    for (int l = 0; l < 3; l++) begin
      send_cfg(8'h60 + 8'(l), 4'd0, 4'd15);
      for (int i = 0; i < 16; i++) send_byte(8'h60 + 8'(16*l + i));
    end
    checks++; if (cyc - t0 !== 51) begin errors++; $display("FAIL t6_throughput got %0d cycles need 51", cyc - t0); end
    checks++; if (busy !== 1'b1 || ram_wr_req !== 1'b1) begin errors++; $display("FAIL t6_last_req got busy=%b req=%b need 1 1", busy, ram_wr_req); end
    tick();
    checks++; if (busy !== 1'b0 || line_done !== 1'b0) begin errors++; $display("FAIL t6_busy_fall got busy=%b done=%b need 0 0", busy, line_done); end
    checks++;
    if (q_addr.size() !== 3) begin
      errors++; $display("FAIL t6_write_count got %0d need 3", q_addr.size());
    end else if (q_addr[0] !== 8'h60 || q_addr[1] !== 8'h61 || q_addr[2] !== 8'h62 ||
                 q_data[2] !== 128'h8F8E8D8C8B8A89888786858483828180) begin
      errors++; $display("FAIL t6_lines got %h %h %h data=%h need 60 61 62 8F..80", q_addr[0], q_addr[1], q_addr[2], q_data[2]);
    end
  endtask

  task automatic test_reset_midline();
    clear_q();
    ram_wr_gnt = 1'b1;
    send_cfg(8'h40, 4'd0, 4'd15);
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i));
    checks++; if (busy !== 1'b1 || in_rdy !== 1'b1) begin errors++; $display("FAIL t5_pre got busy=%b in_rdy=%b need 1 1", busy, in_rdy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cfg_rdy !== 1'b1 || in_rdy !== 1'b0 || ram_wr_req !== 1'b0 || ram_wr_addr !== 8'h00 ||
        ram_wr_data !== 128'h0 || ram_wr_strb !== 16'h0 || line_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t5_async got cfg_rdy=%b in_rdy=%b req=%b addr=%h strb=%h busy=%b done=%b need reset values",
               cfg_rdy, in_rdy, ram_wr_req, ram_wr_addr, ram_wr_strb, busy, line_done);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (cfg_rdy !== 1'b1 || ram_wr_req !== 1'b0 || q_addr.size() !== 0) begin
      errors++; $display("FAIL t5_after got cfg_rdy=%b req=%b writes=%0d need 1 0 0", cfg_rdy, ram_wr_req, q_addr.size()); end
    send_cfg(8'h41, 4'd0, 4'd0);
    send_byte(8'h77);
    tick();
    checks++;
    if (q_addr.size() !== 1) begin
      errors++; $display("FAIL t5_recover_count got %0d need 1", q_addr.size());
    end else if (q_addr[0] !== 8'h41 || q_strb[0] !== 16'h0001 || q_data[0] !== 128'h77) begin
      errors++; $display("FAIL t5_recover got addr=%h strb=%h data=%h need 41 0001 77", q_addr[0], q_strb[0], q_data[0]);
    end
  endtask

  initial begin
    test_reset();
    test_ascending_full();
    test_descending();
    test_single_byte();
    test_backpressure();
    test_back_to_back();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
